// File: rtl/mdu_scheduler.sv
// mdu_scheduler
// Multi-cycle multiply/divide unit for the E stage of the five-stage core.
// It owns HI/LO, holds busy for a fixed number of cycles per multiply or
// divide, and raises the D-stage stall when a following MD-class
// instruction would otherwise see HI/LO before they are final.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   start    - E-stage instruction is an MD operation this cycle
//   op       - 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 no-op
//   a, b     - forwarded rs / rt values
//   d_is_md  - D-stage instruction is an MD-class instruction
//   busy     - a multiply or divide is in flight
//   stall    - freeze PC/F/D and insert a bubble into E
//   hi, lo   - architectural HI/LO registers
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    logic [31:0]        p_hi_reg, p_hi_next;
    logic [31:0]        p_lo_reg, p_lo_next;
    // Cleared for a divide by zero so that completion leaves HI/LO alone.
    logic               p_wr_reg, p_wr_next;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic is_mul, is_div, is_long;

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_long = is_mul || is_div;

    // ------------------------------------------------------------------
    // Arithmetic, computed combinationally from the E-stage operands and
    // parked in p_hi/p_lo until the scheduled completion.
    // ------------------------------------------------------------------
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_den;
    logic [31:0] q_mag, r_mag, q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        b_zero;

    assign b_zero = (b == 32'd0);

    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide is done on magnitudes so that 0x80000000 / -1
        // wraps to 0x80000000 without relying on host integer division.
        abs_a  = a[31] ? (~a + 32'd1) : a;
        abs_b  = b[31] ? (~b + 32'd1) : b;
        // Substitute divisor for b==0 only keeps the dividers well defined;
        // the result is discarded in that case.
        div_den = b_zero ? 32'd1 : abs_b;
        q_mag  = abs_a / div_den;
        r_mag  = abs_a % div_den;
        q_u    = a / (b_zero ? 32'd1 : b);
        r_u    = a % (b_zero ? 32'd1 : b);

        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
            end
            OP_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            p_hi_reg  <= 32'd0;
            p_lo_reg  <= 32'd0;
            p_wr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            p_hi_reg  <= p_hi_next;
            p_lo_reg  <= p_lo_next;
            p_wr_reg  <= p_wr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        p_hi_next  = p_hi_reg;
        p_lo_next  = p_lo_reg;
        p_wr_next  = p_wr_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (is_long) begin
                        p_hi_next  = res_hi;
                        p_lo_next  = res_lo;
                        p_wr_next  = !(is_div && b_zero);
                        cnt_next   = is_mul ? CNT_W'(MULT_CYCLES - 1)
                                            : CNT_W'(DIV_CYCLES - 1);
                        state_next = BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_next = a;
                    end else if (op == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            BUSY: begin
                // Any start here is ignored; the pipeline never issues one.
                if (cnt_reg == '0) begin
                    if (p_wr_reg) begin
                        hi_next = p_hi_reg;
                        lo_next = p_lo_reg;
                    end
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = (state_reg == BUSY);
    // mthi/mtlo are left out: their write lands on the edge the follower
    // enters E, so the follower already sees the new value.
    assign stall = d_is_md && (busy || (start && is_long));
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multi-cycle multiply/divide unit with its own scheduler for the five-stage pipelined MIPS core. It sits beside the ALU in the E stage and accepts `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` operations. It owns the HI/LO registers, holds `busy` for a fixed number of cycles per operation and raises the D-stage stall when a following MD-class instruction would observe HI/LO before they are final.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high after a multiply starts (≥2).
- `DIV_CYCLES`, default 10: cycles `busy` stays high after a divide starts (≥2).
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `start` input 1: E-stage instruction is an MD operation this cycle.
- `op` input 3: 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0 and 7 are no-op.
- `a` input 32: forwarded rs value.
- `b` input 32: forwarded rt value.
- `d_is_md` input 1: D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy` output 1: a multiply or divide is in flight.
- `stall` output 1: freeze PC/F/D and insert a bubble into E.
- `hi` output 32: HI register, read by `mfhi` in E.
- `lo` output 32: LO register, read by `mflo` in E.

## Operation
- States: IDLE, BUSY. Down-counter `cnt` has width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)))+1.
- IDLE + `start` + op∈{1..4}: latch the computed result into pending `p_hi`/`p_lo`, load `cnt` = MULT_CYCLES−1 or DIV_CYCLES−1, go to BUSY.
- BUSY: decrement `cnt` each cycle. When `cnt`==0: copy `p_hi`/`p_lo` to `hi`/`lo` and return to IDLE.
- IDLE + `start` + op=5 or 6: write `a` to `hi` or `lo` at that edge. State stays IDLE.
- `start` while BUSY (any op) is ignored, with no state or register change. The pipeline guarantees this case never happens.
- Op 0 or 7 with `start`: no effect.
- Arithmetic:
  - mult: 64-bit signed product of `a`·`b`; {hi,lo}=product.
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend; 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (`b`==0): operation is still scheduled, with full DIV_CYCLES `busy`, but HI/LO are left unchanged at completion.
- `busy` = (state==BUSY).
- `stall` = `d_is_md` & (`busy` | (`start` & op∈{1..4})). Combinational, no register.
- mthi/mtlo in E never stall a following MD instruction, because the write lands at the same edge the follower enters E.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, `cnt`=0, `hi`=`lo`=`p_hi`=`p_lo`=0, `busy`=0, `stall`=0 unless driven by inputs. `stall` depends only on inputs while in reset.
- Release of reset is synchronous to the next `clk` edge.
- Operation accepted at edge T, i.e. `start` sampled high in the cycle ending at T.
  - `busy`=1 for exactly N cycles, from cycle T+1 through T+N (N = MULT_CYCLES or DIV_CYCLES).
  - New `hi`/`lo` are visible from cycle T+N+1, when `busy` has returned to 0.
- A new `start` in cycle T+N+1 is accepted normally, giving back-to-back operations with no idle gap.
- mthi/mtlo accepted at edge T: new value is visible on `hi`/`lo` from cycle T+1.
- Reset asserted mid-operation: the pending result is discarded and HI/LO go to 0 at once.
- `busy` has zero-cycle latency relative to state; `stall` has zero-cycle latency relative to inputs.

## Test plan
- Reset, then mult with `a`=0xFFFFFFFE (−2), `b`=3 -> `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Check hi/lo are unchanged (0) during `busy`.
- divu with `a`=100, `b`=7 -> `busy` high for 10 cycles; then lo=14, hi=2. div with `a`=−7, `b`=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. div with `b`=0 after hi=0x11, lo=0x22 were set by mthi/mtlo -> 10-cycle `busy`, then hi=0x11, lo=0x22 unchanged.
- Stall window: mult `start` with `d_is_md`=1 held -> `stall`=1 in the start cycle and all 5 `busy` cycles, 0 in the next cycle. With `d_is_md`=0 throughout -> `stall` is never 1.
- `start` with op=3 during the 3rd `busy` cycle of a mult -> ignored; mult result commits on schedule and `busy` falls after cycle 5. mtlo `a`=0x1234 in IDLE -> lo=0x1234 the next cycle, no `busy`.
- Pull `reset` low in the 4th cycle of a div -> `busy`=0 and hi=lo=0 immediately, with no clock edge needed. After release, a new mult runs correctly.
